// File: rtl/fft32_pkg.sv
// fft32_pkg: shared state encoding and sizing constants for the 32-point FFT control path
package fft32_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
  localparam int N_POINTS   = 32;
  localparam int ADDR_W     = 5;
  localparam int TW_W       = 4;
  localparam int N_BFLY     = 16;
  localparam int LAST_STAGE = 4;
  localparam int N_STAGES   = 5;
endpackage

// File: rtl/fft32_bfly_addr_gen.sv
// fft32_bfly_addr_gen: maps (stage, butterfly index) to operand addresses and twiddle index
module fft32_bfly_addr_gen
  import fft32_pkg::*;
(
  input  logic [2:0]        stage,
  input  logic [3:0]        j,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [TW_W-1:0]   tw_idx
);
  logic [ADDR_W-1:0] jj;
  logic [ADDR_W-1:0] lo_mask;
  always_comb begin
    jj      = {1'b0, j};
    lo_mask = (ADDR_W'(1) << stage) - ADDR_W'(1);
    addr_a  = ((jj & ~lo_mask) << 1) | (jj & lo_mask);
    addr_b  = addr_a | (ADDR_W'(1) << stage);
    tw_idx  = (j & lo_mask[TW_W-1:0]) << (3'd4 - stage);
  end
endmodule

// File: rtl/fft32_stage_sequencer.sv
// fft32_stage_sequencer: issues 5 stages x 16 butterflies with inter-stage pipeline drain
module fft32_stage_sequencer
  import fft32_pkg::*;
#(
  parameter int unsigned BF_LAT = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [TW_W-1:0]   tw_idx,
  output logic [2:0]        stage,
  output logic              rot_clr,
  output logic [2:0]        rot_s
);
  state_e            st_q, st_d;
  logic [2:0]        stage_q, stage_d;
  logic [3:0]        j_q, j_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, gen_a, gen_b;
  logic [TW_W-1:0]   tw_idx_q, tw_idx_d, gen_tw;
  logic              rot_clr_q, rot_clr_d;
  logic [2:0]        rot_s_q, rot_s_d;
  fft32_bfly_addr_gen u_gen (
    .stage  (stage_d),
    .j      (j_d),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tw_idx (gen_tw)
  );
  always_comb begin
    st_d    = st_q;
    stage_d = stage_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    unique case (st_q)
      IDLE: begin
        if (start) begin
          st_d    = ISSUE;
          stage_d = '0;
          j_d     = '0;
        end
      end
      ISSUE: begin
        if (out_ready) begin
          j_d = j_q + 4'd1;
          if (j_q == 4'(N_BFLY - 1)) begin
            if (BF_LAT == 0 && stage_q != 3'(LAST_STAGE)) begin
              stage_d = stage_q + 3'd1;
            end else begin
              st_d  = DRAIN;
              cnt_d = 4'(BF_LAT);
            end
          end
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - 4'd1;
        if (stage_q == 3'(LAST_STAGE)) begin
          if (cnt_q == 4'd0) begin
            st_d  = DONE;
            cnt_d = '0;
          end
        end else if (cnt_q == 4'd1) begin
          st_d    = ISSUE;
          stage_d = stage_q + 3'd1;
          j_d     = '0;
        end
      end
      DONE: begin
        st_d    = IDLE;
        stage_d = '0;
        j_d     = '0;
      end
      default: st_d = IDLE;
    endcase
    out_valid_d = st_d == ISSUE;
    busy_d      = st_d == ISSUE || st_d == DRAIN;
    done_d      = st_d == DONE;
    addr_a_d    = out_valid_d ? gen_a : '0;
    addr_b_d    = out_valid_d ? gen_b : '0;
    tw_idx_d    = out_valid_d ? gen_tw : '0;
    rot_clr_d   = stage_d == 3'd0;
    rot_s_d     = (stage_d == 3'd0) ? 3'd0 : stage_d - 3'd1;
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st_q        <= IDLE;
      stage_q     <= '0;
      j_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      tw_idx_q    <= '0;
      rot_clr_q   <= 1'b1;
      rot_s_q     <= '0;
    end else begin
      st_q        <= st_d;
      stage_q     <= stage_d;
      j_q         <= j_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      tw_idx_q    <= tw_idx_d;
      rot_clr_q   <= rot_clr_d;
      rot_s_q     <= rot_s_d;
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign addr_a    = addr_a_q;
  assign addr_b    = addr_b_q;
  assign tw_idx    = tw_idx_q;
  assign stage     = stage_q;
  assign rot_clr   = rot_clr_q;
  assign rot_s     = rot_s_q;
endmodule

// File: tb/tb_fft32_stage_sequencer.sv
// tb_fft32_stage_sequencer: scoreboard bench for issue order, addressing, drain, done timing and aborts
module tb_fft32_stage_sequencer;
  localparam int BF_LAT = 4;
  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic       out_ready = 1'b1;
  logic       busy, done, out_valid, rot_clr;
  logic [4:0] addr_a, addr_b;
  logic [3:0] tw_idx;
  logic [2:0] stage, rot_s;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fires = 0;
  int gap = 0;
  typedef struct {int s; int j; int a; int b; int tw;} iss_t;
  iss_t exp_q[$];
  int   done_q[$];
  iss_t hand[7];
  fft32_stage_sequencer #(.BF_LAT(BF_LAT)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .tw_idx    (tw_idx),
    .stage     (stage),
    .rot_clr   (rot_clr),
    .rot_s     (rot_s)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask
  function automatic iss_t model(input int s, input int j);
    iss_t e;
    int k = 0;
    e.s = s;
    e.j = j;
    e.a = 0;
    for (int p = 0; p < 5; p++) begin
      if (p != s) begin
        e.a = e.a | (((j >> k) & 1) << p);
        k++;
      end
    end
    e.b  = e.a + (1 << s);
    e.tw = ((j % (1 << s)) << (4 - s)) & 15;
    return e;
  endfunction
  always @(negedge clk) begin
    iss_t e;
    if (!busy) gap = 0;
    if (out_valid && out_ready) begin
      fires++;
      if (exp_q.size() == 0) chk("unexpected_issue", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("addr_a", addr_a, e.a);
        chk("addr_b", addr_b, e.b);
        chk("tw_idx", tw_idx, e.tw);
        chk("stage", stage, e.s);
        chk("rot_clr", rot_clr, e.s == 0);
        chk("rot_s", rot_s, e.s == 0 ? 0 : e.s - 1);
        for (int h = 0; h < 7; h++) begin
          if (hand[h].s == e.s && hand[h].j == e.j) begin
            chk("hand_a", addr_a, hand[h].a);
            chk("hand_b", addr_b, hand[h].b);
            chk("hand_tw", tw_idx, hand[h].tw);
          end
        end
      end
    end
    if (busy && !out_valid) gap++;
    else if (out_valid && gap > 0) begin
      chk("drain_gap", gap, BF_LAT);
      gap = 0;
    end
    if (done) begin
      chk("done_busy", busy, 0);
      if (done_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("done_cycle", cyc, done_q.pop_front());
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input int extra);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < 5; s++)
      for (int j = 0; j < 16; j++) exp_q.push_back(model(s, j));
    done_q.push_back(cyc + 5 * (16 + BF_LAT) + 1 + extra);
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask
  task automatic wait_issue(input int s, input int a);
    int n = 0;
    while (!(out_valid && stage == 3'(s) && addr_a == 5'(a)) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) chk("issue_timeout", 0, 1);
  endtask
  initial begin
    hand[0] = '{0, 0, 0, 1, 0};
    hand[1] = '{0, 15, 30, 31, 0};
    hand[2] = '{2, 5, 9, 13, 4};
    hand[3] = '{4, 15, 15, 31, 15};
    hand[4] = '{1, 3, 5, 7, 8};
    hand[5] = '{1, 7, 13, 15, 8};
    hand[6] = '{3, 6, 6, 14, 12};
    #2 clr = 1'b0;
    #10;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_a", addr_a, 0);
    chk("rst_b", addr_b, 0);
    chk("rst_tw", tw_idx, 0);
    chk("rst_stage", stage, 0);
    chk("rst_rot_clr", rot_clr, 1);
    chk("rst_rot_s", rot_s, 0);
    tick();
    clr = 1'b1;
    tick();
    fires = 0;
    do_start(0);
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("issue_count_1", fires, 80);
    repeat (30) tick();
    chk("no_restart_busy", busy, 0);
    chk("no_restart_valid", out_valid, 0);
    fires = 0;
    do_start(3);
    wait_issue(1, 13);
    out_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_a", addr_a, 13);
      chk("bp_b", addr_b, 15);
      chk("bp_tw", tw_idx, 8);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_advance_a", addr_a, 16);
    wait_done();
    tick();
    chk("issue_count_2", fires, 80);
    fires = 0;
    do_start(0);
    wait_issue(3, 6);
    clr = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_a", addr_a, 0);
    chk("abort_stage", stage, 0);
    chk("abort_rot_clr", rot_clr, 1);
    exp_q.delete();
    done_q.delete();
    repeat (5) tick();
    clr = 1'b1;
    repeat (3) tick();
    chk("abort_idle", busy, 0);
    fires = 0;
    do_start(0);
    wait_done();
    tick();
    chk("issue_count_3", fires, 80);
    repeat (5) tick();
    chk("queue_empty", exp_q.size(), 0);
    chk("done_queue_empty", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
